// File: rtl/sinegen_pkg.sv
// Shared types and constants for the sine generator phase accumulator.
package sinegen_pkg;

    localparam int unsigned ADDRESS_WIDTH_DEF = 8;
    localparam int unsigned ACC_WIDTH_DEF     = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PENDING
    } state_t;

    // Increment that advances the ROM address by exactly one per clock.
    function automatic int unsigned default_incr(input int unsigned acc_w, input int unsigned addr_w);
        return 32'd1 << (acc_w - addr_w);
    endfunction

endpackage

// File: rtl/sinegen_valid_delay_pipe.sv
// N-stage single-bit delay line with asynchronous active-low clear.
module valid_delay_pipe #(
    parameter int unsigned STAGES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            pipe[0] <= din;
            for (int unsigned i = 1; i < STAGES; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[STAGES-1];

endmodule

// File: rtl/sinegen_phase_acc.sv
// Phase-accumulator address generator for the dual-read sine ROM; new
// frequency/offset settings are applied only at a phase wrap while running.
module sinegen_phase_acc
    import sinegen_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int unsigned ACC_WIDTH     = ACC_WIDTH_DEF,
    parameter int unsigned DEFAULT_INCR  = default_incr(ACC_WIDTH, ADDRESS_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [ACC_WIDTH-1:0]     incr_in,
    input  logic [ADDRESS_WIDTH-1:0] offset_in,
    output logic [ADDRESS_WIDTH-1:0] addr1,
    output logic [ADDRESS_WIDTH-1:0] offset,
    output logic                     addr_valid,
    output logic                     dout_valid,
    output logic                     sync
);

    localparam logic [ACC_WIDTH-1:0] RST_INCR = ACC_WIDTH'(DEFAULT_INCR);

    state_t                   state;
    logic [ACC_WIDTH-1:0]     acc;
    logic [ACC_WIDTH-1:0]     active_incr;
    logic [ACC_WIDTH-1:0]     shadow_incr;
    logic [ADDRESS_WIDTH-1:0] active_offset;
    logic [ADDRESS_WIDTH-1:0] shadow_offset;
    logic [ACC_WIDTH:0]       sum;
    logic                     wrap;
    logic                     handshake;

    assign sum       = {1'b0, acc} + {1'b0, active_incr};
    assign wrap      = sum[ACC_WIDTH];
    assign handshake = cfg_valid & cfg_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cfg_ready     <= 1'b1;
            acc           <= '0;
            active_incr   <= RST_INCR;
            active_offset <= '0;
            shadow_incr   <= '0;
            shadow_offset <= '0;
        end else begin
            if (en) begin
                acc <= sum[ACC_WIDTH-1:0];
            end
            case (state)
                IDLE: begin
                    cfg_ready <= 1'b1;
                    if (handshake) begin
                        active_incr   <= incr_in;
                        active_offset <= offset_in;
                    end
                    if (en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Stopping and configuring on the same clock applies directly, as in IDLE.
                    if (!en) begin
                        state     <= IDLE;
                        cfg_ready <= 1'b1;
                        if (handshake) begin
                            active_incr   <= incr_in;
                            active_offset <= offset_in;
                        end
                    end else if (handshake) begin
                        shadow_incr   <= incr_in;
                        shadow_offset <= offset_in;
                        state         <= PENDING;
                        cfg_ready     <= 1'b0;
                    end
                end
                PENDING: begin
                    if (!en || wrap) begin
                        active_incr   <= shadow_incr;
                        active_offset <= shadow_offset;
                        state         <= en ? RUN : IDLE;
                        cfg_ready     <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

    assign addr1  = acc[ACC_WIDTH-1 -: ADDRESS_WIDTH];
    assign offset = active_offset;

    valid_delay_pipe #(.STAGES(1)) u_addr_valid (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (en),
        .dout  (addr_valid)
    );

    valid_delay_pipe #(.STAGES(1)) u_dout_valid (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (addr_valid),
        .dout  (dout_valid)
    );

    valid_delay_pipe #(.STAGES(2)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (en & wrap),
        .dout  (sync)
    );

endmodule

// File: tb/tb_sinegen_phase_acc.sv
// Self-checking bench for sinegen_phase_acc against an arithmetic phase model.
module tb_sinegen_phase_acc;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] incr_in;
    logic [7:0]  offset_in;
    logic [7:0]  addr1;
    logic [7:0]  offset;
    logic        addr_valid;
    logic        dout_valid;
    logic        sync;

    int checks = 0;
    int errors = 0;

    // Model state: phase as a plain integer on a 65536-step circle.
    int unsigned m_phase, m_incr, m_off, p_incr, p_off;
    bit          m_pend, m_run;
    bit          en_d1, en_d2, w_d1, w_d2;

    sinegen_phase_acc #(
        .ADDRESS_WIDTH (8),
        .ACC_WIDTH     (16),
        .DEFAULT_INCR  (256)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .incr_in    (incr_in),
        .offset_in  (offset_in),
        .addr1      (addr1),
        .offset     (offset),
        .addr_valid (addr_valid),
        .dout_valid (dout_valid),
        .sync       (sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_incr = 256; m_off = 0; p_incr = 0; p_off = 0;
        m_pend = 0; m_run = 0;
        en_d1 = 0; en_d2 = 0; w_d1 = 0; w_d2 = 0;
    endtask

    task automatic model_step();
        bit hs, w;
        hs = cfg_valid && !m_pend;
        w  = en && (m_phase + m_incr >= 65536);
        if (en) m_phase = (m_phase + m_incr) % 65536;
        if (!m_pend) begin
            if (hs && m_run && en) begin
                m_pend = 1; p_incr = incr_in; p_off = offset_in;
            end else if (hs) begin
                m_incr = incr_in; m_off = offset_in;
            end
            m_run = en;
        end else if (!en || w) begin
            m_incr = p_incr; m_off = p_off; m_pend = 0; m_run = en;
        end
        en_d2 = en_d1; en_d1 = en;
        w_d2 = w_d1;   w_d1 = w;
    endtask

    task automatic compare_all();
        chk("addr1",      addr1,      int'(m_phase / 256));
        chk("offset",     offset,     int'(m_off));
        chk("cfg_ready",  cfg_ready,  int'(!m_pend));
        chk("addr_valid", addr_valid, int'(en_d1));
        chk("dout_valid", dout_valid, int'(en_d2));
        chk("sync",       sync,       int'(w_d2));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        compare_all();
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_addr1",      addr1,      0);
        chk("rst_offset",     offset,     0);
        chk("rst_cfg_ready",  cfg_ready,  1);
        chk("rst_addr_valid", addr_valid, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_sync",       sync,       0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cfg(input int unsigned inc, input int unsigned off);
        cfg_valid = 1'b1; incr_in = 16'(inc); offset_in = 8'(off);
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        int sync_cnt;
        rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; incr_in = '0; offset_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        compare_all();
        chk("init_ready", cfg_ready, 1);
        chk("init_valid", addr_valid, 0);

        // Default increment: one address per clock, wrap and sync alignment.
        en = 1'b1;
        step();
        chk("dflt_addr1_first", addr1, 1);
        chk("dflt_avalid_first", addr_valid, 1);
        chk("dflt_dvalid_first", dout_valid, 0);
        step();
        chk("dflt_dvalid_second", dout_valid, 1);
        repeat (253) step();
        chk("dflt_addr1_255", addr1, 255);
        step();
        chk("dflt_addr1_wrap", addr1, 0);
        chk("dflt_sync_early", sync, 0);
        step();
        chk("dflt_sync_pulse", sync, 1);
        step();
        chk("dflt_sync_end", sync, 0);

        // Configuration in IDLE applies directly.
        en = 1'b0;
        step();
        cfg(512, 64);
        chk("idle_offset", offset, 64);
        chk("idle_ready", cfg_ready, 1);
        en = 1'b1;
        step();
        chk("idle_addr_step2", addr1, 4);

        // Handshake in RUN at addr1=10 waits for the next wrap.
        async_reset();
        en = 1'b1;
        repeat (10) step();
        chk("run_addr10", addr1, 10);
        cfg(1024, 33);
        chk("run_pending_ready", cfg_ready, 0);
        chk("run_pending_offset", offset, 0);
        repeat (244) step();
        chk("run_addr255", addr1, 255);
        step();
        chk("run_wrap_addr", addr1, 0);
        chk("run_wrap_ready", cfg_ready, 1);
        chk("run_wrap_offset", offset, 33);
        step();
        chk("run_new_step", addr1, 4);

        // PENDING then en=0 applies the shadow immediately.
        cfg(256, 5);
        chk("pend_ready", cfg_ready, 0);
        en = 1'b0;
        step();
        chk("stop_ready", cfg_ready, 1);
        chk("stop_offset", offset, 5);
        chk("stop_avalid", addr_valid, 0);
        chk("stop_dvalid", dout_valid, 1);
        step();
        chk("stop_dvalid_late", dout_valid, 0);

        // Fractional increment: two wraps per 1024 clocks.
        cfg(128, 0);
        en = 1'b1;
        sync_cnt = 0;
        for (int i = 0; i < 1025; i++) begin
            step();
            if (sync) sync_cnt++;
        end
        chk("frac_sync_count", sync_cnt, 2);

        // Reset while a configuration is pending.
        cfg(1024, 99);
        chk("pend2_ready", cfg_ready, 0);
        repeat (3) step();
        async_reset();
        en = 1'b1;
        step();
        chk("post_rst_addr1", addr1, 1);
        chk("post_rst_offset", offset, 0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            en = ($urandom_range(0, 19) != 0);
            cfg_valid = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 4))
                0: incr_in = 16'd0;
                1: incr_in = 16'($urandom_range(1, 255));
                2: incr_in = 16'($urandom_range(256, 4096));
                3: incr_in = 16'($urandom_range(4096, 65535));
                default: incr_in = 16'(256 * $urandom_range(1, 255));
            endcase
            offset_in = 8'($urandom_range(0, 255));
            step();
        end
        cfg_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
